// File: rtl/mix_columns_seq.sv
// mix_columns_seq: column-serial AES MixColumns (enc_dec=0) / InvMixColumns (enc_dec=1), one column per clock; ports clk, rst, in_valid/in_ready/in_state, in_last (only with MIXCOL_LAST_ROUND_EN), out_valid/out_ready/out_state
module mix_columns_seq #(
  parameter bit enc_dec = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
`ifdef MIXCOL_LAST_ROUND_EN
  input  logic         in_last,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [15:0] coef = enc_dec ? 16'hebd9 : 16'h2311;
  state_t state;
  logic [1:0] col;
  logic [0:127] st;
  logic [31:0] a, b;
  logic last, accept;
`ifdef MIXCOL_LAST_ROUND_EN
  assign last = in_last;
`else
  assign last = 1'b0;
`endif
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_state = st;
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul(input logic [7:0] v, input logic [3:0] c);
    logic [7:0] v2, v4, v8;
    v2 = xt(v);
    v4 = xt(v2);
    v8 = xt(v4);
    return (c[0] ? v : 8'h00) ^ (c[1] ? v2 : 8'h00) ^ (c[2] ? v4 : 8'h00) ^ (c[3] ? v8 : 8'h00);
  endfunction
  always_comb begin
    a = st[{col, 5'd0} +: 32];
    b = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        b[31-8*r -: 8] = b[31-8*r -: 8] ^ mul(a[31-8*((r+k)%4) -: 8], coef[15-4*k -: 4]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      col <= 2'd0;
      st <= '0;
      out_valid <= 1'b0;
    end else if (state == BUSY) begin
      st[{col, 5'd0} +: 32] <= b;
      col <= col + 2'd1;
      if (col == 2'd3) begin
        state <= DONE;
        out_valid <= 1'b1;
      end
    end else if (accept) begin
      st <= in_state;
      col <= 2'd0;
      state <= last ? DONE : BUSY;
      out_valid <= last;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed scoreboard bench for mix_columns_seq (encrypt and decrypt instances)
module tb_mix_columns_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [0:127] in_state = '0, out_state;
  logic d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0;
  logic [0:127] d_in_state = '0, d_out_state;
`ifdef MIXCOL_LAST_ROUND_EN
  logic in_last = 1'b0;
  logic d_in_last = 1'b0;
`endif
  int total = 0, bad = 0, retired = 0, cyc = 0, last_acc = 0;
  logic [0:127] exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mix_columns_seq #(.enc_dec(1'b0)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
`ifdef MIXCOL_LAST_ROUND_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state));
  mix_columns_seq #(.enc_dec(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_state(d_in_state),
`ifdef MIXCOL_LAST_ROUND_EN
    .in_last(d_in_last),
`endif
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_state(d_out_state));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_output observed=%h expected=none", out_state);
      end
      if (exp_q.size() != 0) chk("scoreboard", out_state, exp_q.pop_front());
      retired++;
    end
  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [0:127] mix(input logic [0:127] s, input bit inv);
    logic [7:0] m [4];
    logic [7:0] v;
    logic [0:127] r;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        v = 8'h00;
        for (int k = 0; k < 4; k++) v ^= gm(s[(4*c+(w+k)%4)*8 +: 8], m[k]);
        r[(4*c+w)*8 +: 8] = v;
      end
    return r;
  endfunction
  function automatic logic [0:127] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [0:127] s, input logic [0:127] e, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_state = s;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("accept_bound", 128'(n < 50), 128'(1));
    if (push) exp_q.push_back(e);
    tick();
    last_acc = cyc;
    in_valid = 1'b0;
    in_state = ~s;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
  endtask
  initial begin
    logic [0:127] v1, c1, dv, dc, s, sb;
    int n, r0;
    int acc [8];
    v1 = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    c1 = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
    dv = {32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8};
    dc = {32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c};
    tick();
    tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_d_out_valid", 128'(d_out_valid), 128'(0));
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    send(v1, c1, 1'b1);
    chk("busy_in_ready", 128'(in_ready), 128'(0));
    chk("busy_out_valid", 128'(out_valid), 128'(0));
    wait_out(n);
    chk("enc_latency", 128'(n), 128'(4));
    tick();
    d_in_valid = 1'b1;
    d_in_state = dv;
    tick();
    d_in_valid = 1'b0;
    d_in_state = '0;
    n = 0;
    while (!d_out_valid && n < 20) begin tick(); n++; end
    chk("dec_latency", 128'(n), 128'(4));
    chk("dec_state", d_out_state, dc);
    d_out_ready = 1'b1;
    tick();
    chk("dec_retire", 128'(d_out_valid), 128'(0));
    out_ready = 1'b0;
    s = rnd();
    send(s, mix(s, 1'b0), 1'b1);
    wait_out(n);
    chk("bp_latency", 128'(n), 128'(4));
    sb = rnd();
    in_valid = 1'b1;
    in_state = sb;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_state", out_state, mix(s, 1'b0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 128'(in_ready), 128'(1));
    exp_q.push_back(mix(sb, 1'b0));
    tick();
    in_valid = 1'b0;
    in_state = ~sb;
    chk("bp_reaccept_busy", 128'(out_valid), 128'(0));
    wait_out(n);
    chk("bp_new_latency", 128'(n), 128'(4));
    tick();
    r0 = retired;
    for (int i = 0; i < 8; i++) begin
      s = rnd();
      send(s, mix(s, 1'b0), 1'b1);
      acc[i] = last_acc;
      if (i > 0) chk("stream_gap", 128'(acc[i] - acc[i-1]), 128'(5));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
    chk("stream_drain", 128'(exp_q.size()), 128'(0));
    chk("stream_count", 128'(retired - r0), 128'(8));
    tick();
    s = rnd();
    send(s, mix(s, 1'b0), 1'b0);
    tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_state", out_state, 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_idle", 128'(out_valid), 128'(0));
    s = rnd();
    send(s, mix(s, 1'b0), 1'b1);
    wait_out(n);
    chk("midrst_latency", 128'(n), 128'(4));
    tick();
`ifdef MIXCOL_LAST_ROUND_EN
    in_last = 1'b1;
    send(v1, v1, 1'b1);
    in_last = 1'b0;
    chk("last_out_valid", 128'(out_valid), 128'(1));
    chk("last_state", out_state, v1);
    tick();
    s = rnd();
    send(s, mix(s, 1'b0), 1'b1);
    wait_out(n);
    chk("last0_latency", 128'(n), 128'(4));
    tick();
`endif
    tick();
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
